fifo_wr_frontend: RTL and testbench

- Write-side front end of the async FIFO, in the wclk domain, directly upstream of the write-pointer/full logic.
- Converts a valid/ready source stream into the FIFO's winc/wdata write port through a 2-entry skid buffer, so a combinational wfull never reaches the source.
- Computes a registered fill level and almost-full flag from the write pointer and the synchronised read pointer, both Gray-coded.

---
 rtl/fifo_wr_frontend.sv | 120 ++++++++++++
 tb/tb_fifo_wr_frontend.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_frontend.sv
// Write-side front end of the async FIFO: 2-entry skid buffer from a valid/ready source onto winc/wdata,
// plus registered fill level / almost-full. Optional macro WR_AF_THROTTLE_EN gates s_ready on almost-full.
module fifo_wr_frontend #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_RANGE = 3,
  parameter int AF_THRESH  = 6
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  wfull,
  input  logic [ADDR_RANGE:0]   wptr,
  input  logic [ADDR_RANGE:0]   sync_rptr,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [ADDR_RANGE:0]   wlevel,
  output logic                  walmost_full,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [ADDR_RANGE:0] AF_T = AF_THRESH[ADDR_RANGE:0];

  function automatic logic [ADDR_RANGE:0] gray2bin(input logic [ADDR_RANGE:0] g);
    logic [ADDR_RANGE:0] b;
    b[ADDR_RANGE] = g[ADDR_RANGE];
    for (int i = ADDR_RANGE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  r_s_ready;
  logic [ADDR_RANGE:0]   r_wlevel;
  logic                  r_af;

  logic                  w_accept;
  logic                  w_pop;
  logic [ADDR_RANGE:0]   w_level;
  logic                  w_af;
  logic                  w_room;

  // Source side: a word transfers on any edge where s_valid && s_ready; s_valid may not be
  // withdrawn by the source before that. FIFO side: a word leaves on any edge where winc is high.
  assign w_accept = s_valid && r_s_ready;
  assign w_pop    = (r_state != ST_EMPTY) && !wfull;

  // Modular subtraction absorbs pointer wrap; stale sync_rptr only ever overstates the level.
  assign w_level  = gray2bin(wptr) - gray2bin(sync_rptr);
  assign w_af     = (w_level >= AF_T);

`ifdef WR_AF_THROTTLE_EN
  assign w_room = !w_af;
`else
  assign w_room = 1'b1;
`endif

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state   <= ST_EMPTY;
      r_main    <= '0;
      r_skid    <= '0;
      r_s_ready <= 1'b0;
      r_wlevel  <= '0;
      r_af      <= 1'b0;
    end else begin
      r_wlevel  <= w_level;
      r_af      <= w_af;
      r_s_ready <= w_room;
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state <= ST_ONE;
            r_main  <= s_data;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            r_main <= s_data;
          end else if (w_accept) begin
            r_state   <= ST_TWO;
            r_skid    <= s_data;
            r_s_ready <= 1'b0;
          end else if (w_pop) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // s_ready is low here, so no accept can arrive alongside the pop.
          if (w_pop) begin
            r_state <= ST_ONE;
            r_main  <= r_skid;
          end else begin
            r_s_ready <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_EMPTY;
          r_s_ready <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready      = r_s_ready;
  assign winc         = w_pop;
  assign wdata        = r_main;
  assign wlevel       = r_wlevel;
  assign walmost_full = r_af;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// Directed bench for fifo_wr_frontend (default build): reset, streaming into a modelled FIFO,
// backpressure, back-to-back traffic, level wrap arithmetic and mid-operation reset.
module tb_fifo_wr_frontend;

  logic       wclk;
  logic       wrst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       wfull;
  logic [3:0] wptr;
  logic [3:0] sync_rptr;
  logic       winc;
  logic [7:0] wdata;
  logic [3:0] wlevel;
  logic       walmost_full;
  logic [1:0] o_dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  // Pointer-stage stand-in: model_en counts writes with sync_rptr at 0, otherwise manual values.
  logic       model_en;
  logic [3:0] tb_wbin;
  logic [3:0] man_wptr;
  logic [3:0] man_rptr;
  logic       man_full;

  fifo_wr_frontend #(
    .DATA_WIDTH(8),
    .ADDR_RANGE(3),
    .AF_THRESH (6)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .wfull       (wfull),
    .wptr        (wptr),
    .sync_rptr   (sync_rptr),
    .winc        (winc),
    .wdata       (wdata),
    .wlevel      (wlevel),
    .walmost_full(walmost_full),
    .o_dbg_state (o_dbg_state)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  always_comb begin
    wptr      = model_en ? (tb_wbin ^ (tb_wbin >> 1)) : man_wptr;
    wfull     = model_en ? (tb_wbin == 4'd8) : man_full;
    sync_rptr = man_rptr;
  end

  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) tb_wbin <= 4'd0;
    else if (model_en && winc) tb_wbin <= tb_wbin + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    for (int n = 0; n < budget && s_ready !== 1'b1; n++) tick();
    chk("ready_wait", {31'd0, s_ready}, 32'd1);
  endtask

  // Scoreboard: each write strobe must carry the oldest accepted word still outstanding.
  always @(negedge wclk) begin
    logic [7:0] e;
    if (wrst_n) begin
      if (winc) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 8'hxx;
        chk("sb_wdata", {24'd0, wdata}, {24'd0, e});
      end
      if (s_valid && s_ready) exp_q.push_back(s_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] lvl;
    wrst_n   = 1'b0;
    s_valid  = 1'b1;
    s_data   = 8'h55;
    model_en = 1'b1;
    man_wptr = 4'd0;
    man_rptr = 4'd0;
    man_full = 1'b0;

    // 1. Reset held with s_valid high
    repeat (3) tick();
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_winc", {31'd0, winc}, 32'd0);
    chk("rst_wlevel", {28'd0, wlevel}, 32'd0);
    chk("rst_wdata", {24'd0, wdata}, 32'd0);
    chk("rst_af", {31'd0, walmost_full}, 32'd0);
    s_valid = 1'b0;
    wrst_n  = 1'b1;
    #1;
    chk("rel_ready_pre", {31'd0, s_ready}, 32'd0);
    tick();
    chk("rel_ready_post", {31'd0, s_ready}, 32'd1);
    chk("rel_winc", {31'd0, winc}, 32'd0);
    chk("rel_state", {30'd0, o_dbg_state}, 32'd0);

    // 2. Streaming 0x01..0x0A into an 8-deep FIFO with the read side parked
    for (int i = 1; i <= 10; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      wait_ready(4);
      tick();
      lvl = (i < 2) ? 4'd0 : 4'(i - 2);
      chk("str_wlevel", {28'd0, wlevel}, {28'd0, lvl});
      chk("str_af", {31'd0, walmost_full}, {31'd0, (lvl >= 4'd6)});
      chk("str_winc", {31'd0, winc}, {31'd0, (i <= 8)});
      chk("str_wdata", {24'd0, wdata}, (i <= 9) ? 32'(i) : 32'h09);
      chk("str_s_ready", {31'd0, s_ready}, {31'd0, (i <= 9)});
      chk("str_state", {30'd0, o_dbg_state}, (i <= 9) ? 32'd1 : 32'd2);
    end
    s_valid = 1'b0;
    tick();
    chk("str_full_lvl", {28'd0, wlevel}, 32'd8);
    chk("str_wfull", {31'd0, wfull}, 32'd1);
    chk("str_hold_winc", {31'd0, winc}, 32'd0);

    // Drain 0x09/0x0A by handing the pointer stage back to manual control
    model_en = 1'b0;
    #1;
    chk("drn_winc0", {31'd0, winc}, 32'd1);
    chk("drn_wdata0", {24'd0, wdata}, 32'h09);
    tick();
    chk("drn_wdata1", {24'd0, wdata}, 32'h0A);
    chk("drn_ready1", {31'd0, s_ready}, 32'd1);
    tick();
    chk("drn_winc2", {31'd0, winc}, 32'd0);
    chk("drn_state", {30'd0, o_dbg_state}, 32'd0);
    chk("drn_wlevel", {28'd0, wlevel}, 32'd0);

    // 3. Backpressure: wfull forced, three words offered
    man_full = 1'b1;
    s_valid  = 1'b1;
    s_data   = 8'hA1;
    tick();
    chk("bp_state1", {30'd0, o_dbg_state}, 32'd1);
    chk("bp_winc1", {31'd0, winc}, 32'd0);
    s_data = 8'hA2;
    tick();
    chk("bp_state2", {30'd0, o_dbg_state}, 32'd2);
    s_data = 8'hA3;
    repeat (3) begin
      tick();
      chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
      chk("bp_winc", {31'd0, winc}, 32'd0);
      chk("bp_wdata", {24'd0, wdata}, 32'hA1);
    end
    man_full = 1'b0;
    #1;
    chk("bp_rel_winc0", {31'd0, winc}, 32'd1);
    chk("bp_rel_wdata0", {24'd0, wdata}, 32'hA1);
    tick();
    chk("bp_rel_winc1", {31'd0, winc}, 32'd1);
    chk("bp_rel_wdata1", {24'd0, wdata}, 32'hA2);
    chk("bp_rel_ready", {31'd0, s_ready}, 32'd1);
    tick();
    chk("bp_a3_wdata", {24'd0, wdata}, 32'hA3);
    chk("bp_a3_winc", {31'd0, winc}, 32'd1);
    s_valid = 1'b0;
    tick();
    chk("bp_end_state", {30'd0, o_dbg_state}, 32'd0);

    // 4. Back-to-back traffic, no backpressure
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1;
      s_data  = 8'h30 + 8'(i);
      tick();
      chk("b2b_state", {30'd0, o_dbg_state}, 32'd1);
      chk("b2b_winc", {31'd0, winc}, 32'd1);
      chk("b2b_wdata", {24'd0, wdata}, 32'h30 + 32'(i));
      chk("b2b_ready", {31'd0, s_ready}, 32'd1);
    end
    s_valid = 1'b0;
    tick();
    chk("b2b_end_state", {30'd0, o_dbg_state}, 32'd0);

    // 5. Level wrap arithmetic
    man_wptr = 4'b1101; man_rptr = 4'b0010;
    tick();
    chk("wrap_a_lvl", {28'd0, wlevel}, 32'd6);
    chk("wrap_a_af", {31'd0, walmost_full}, 32'd1);
    man_wptr = 4'b0001; man_rptr = 4'b1011;
    tick();
    chk("wrap_b_lvl", {28'd0, wlevel}, 32'd4);
    chk("wrap_b_af", {31'd0, walmost_full}, 32'd0);
    man_wptr = 4'b0111; man_rptr = 4'b0000;
    tick();
    chk("lvl5", {28'd0, wlevel}, 32'd5);
    chk("lvl5_af", {31'd0, walmost_full}, 32'd0);
    man_wptr = 4'b1100;
    tick();
    chk("lvl8", {28'd0, wlevel}, 32'd8);
    chk("lvl8_af", {31'd0, walmost_full}, 32'd1);

    // 6. Reset while two words are buffered
    man_full = 1'b1;
    s_valid  = 1'b1;
    s_data   = 8'hB1;
    tick();
    s_data = 8'hB2;
    tick();
    s_data = 8'hB3;
    tick();
    chk("mrst_pre_state", {30'd0, o_dbg_state}, 32'd2);
    chk("mrst_pre_lvl", {28'd0, wlevel}, 32'd8);
    wrst_n = 1'b0;
    #1;
    chk("mrst_winc", {31'd0, winc}, 32'd0);
    chk("mrst_ready", {31'd0, s_ready}, 32'd0);
    chk("mrst_wlevel", {28'd0, wlevel}, 32'd0);
    chk("mrst_wdata", {24'd0, wdata}, 32'd0);
    exp_q.delete();
    s_valid  = 1'b0;
    man_full = 1'b0;
    man_wptr = 4'd0;
    tick();
    wrst_n = 1'b1;
    tick();
    chk("mrst_rel_ready", {31'd0, s_ready}, 32'd1);
    chk("mrst_rel_winc", {31'd0, winc}, 32'd0);
    s_valid = 1'b1;
    s_data  = 8'hC5;
    tick();
    chk("mrst_new_winc", {31'd0, winc}, 32'd1);
    chk("mrst_new_wdata", {24'd0, wdata}, 32'hC5);
    s_valid = 1'b0;
    tick();
    chk("mrst_end_winc", {31'd0, winc}, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
